// File: rtl/stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch
// Brief    : MM:SS BCD up-counting stopwatch with run/pause/clear, saturating
//            at MAX_MIN:59. Optional lap capture enabled by STOPWATCH_LAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch #(
   parameter int MAX_MIN = 99
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       clk_div,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       lap_view,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   localparam logic [3:0]  c_MAX_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0]  c_MAX_ONES = 4'(MAX_MIN % 10);
   localparam logic [15:0] c_CNT_MAX  = {c_MAX_TENS, c_MAX_ONES, 4'd5, 4'd9};

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic        r_overflow, w_overflow_nxt;
   logic [15:0] w_disp;
   logic        w_tick, w_sat, w_do_clear;

   assign w_tick     = (r_state == S_RUN) && clk_div;
   assign w_sat      = w_tick && (r_cnt == c_CNT_MAX);
   assign w_do_clear = clear && (r_state != S_RUN);

   // BCD ripple increment: {min_tens, min_ones, sec_tens, sec_ones}
   always_comb begin
      w_cnt_inc = r_cnt;
      if (r_cnt[3:0] != 4'd9) begin
         w_cnt_inc[3:0] = r_cnt[3:0] + 4'd1;
      end else begin
         w_cnt_inc[3:0] = 4'd0;
         if (r_cnt[7:4] != 4'd5) begin
            w_cnt_inc[7:4] = r_cnt[7:4] + 4'd1;
         end else begin
            w_cnt_inc[7:4] = 4'd0;
            if (r_cnt[11:8] != 4'd9) begin
               w_cnt_inc[11:8] = r_cnt[11:8] + 4'd1;
            end else begin
               w_cnt_inc[11:8]  = 4'd0;
               w_cnt_inc[15:12] = r_cnt[15:12] + 4'd1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_overflow_nxt = r_overflow;
      // Tick is judged on the current state, so it still counts alongside RUN->PAUSE
      if (w_tick) begin
         if (w_sat) begin
            w_overflow_nxt = 1'b1;
            w_state_nxt    = S_PAUSE;
         end else begin
            w_cnt_nxt = w_cnt_inc;
         end
      end
      case (r_state)
         S_IDLE: begin
            if (clear) begin
               w_cnt_nxt      = 16'd0;
               w_overflow_nxt = 1'b0;
            end else if (start_stop) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (start_stop && !clear) begin
               w_state_nxt = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (clear) begin
               w_state_nxt    = S_IDLE;
               w_cnt_nxt      = 16'd0;
               w_overflow_nxt = 1'b0;
            end else if (start_stop && !r_overflow) begin
               w_state_nxt = S_RUN;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 16'd0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [15:0] r_lap_reg, w_lap_reg_nxt;
   logic        r_lap_view, w_lap_view_nxt;
   logic        w_lap_req;

   // Lap loses to both clear and start_stop in the same cycle
   assign w_lap_req = lap && !clear && !start_stop;

   always_comb begin
      w_lap_reg_nxt  = r_lap_reg;
      w_lap_view_nxt = r_lap_view;
      if (w_do_clear) begin
         w_lap_reg_nxt  = 16'd0;
         w_lap_view_nxt = 1'b0;
      end else if (w_lap_req) begin
         if (r_state == S_RUN) begin
            w_lap_reg_nxt  = r_cnt;
            w_lap_view_nxt = 1'b1;
         end else if (r_state == S_PAUSE) begin
            w_lap_view_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_lap_reg  <= 16'd0;
         r_lap_view <= 1'b0;
      end else begin
         r_lap_reg  <= w_lap_reg_nxt;
         r_lap_view <= w_lap_view_nxt;
      end
   end

   assign w_disp   = r_lap_view ? r_lap_reg : r_cnt;
   assign lap_view = r_lap_view;
`else
   logic w_unused_lap;
   assign w_unused_lap = lap ^ w_do_clear;
   assign w_disp       = r_cnt;
   assign lap_view     = 1'b0;
`endif

   assign min_tens = w_disp[15:12];
   assign min_ones = w_disp[11:8];
   assign sec_tens = w_disp[7:4];
   assign sec_ones = w_disp[3:0];
   assign running  = (r_state == S_RUN);
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch
// Brief    : Table-driven directed vectors plus randomized run against an
//            elapsed-seconds reference model for stopwatch (MAX_MIN = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch;

   localparam int MAX_MIN  = 3;
   localparam int MAX_SECS = MAX_MIN * 60 + 59;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       clk_div = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, lap_view, overflow;

   int errors = 0;
   int checks = 0;

   stopwatch #(.MAX_MIN(MAX_MIN)) dut (
      .clk(clk), .nrst(nrst), .clk_div(clk_div), .start_stop(start_stop),
      .lap(lap), .clear(clear),
      .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .lap_view(lap_view), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0=idle 1=run 2=pause, time kept as elapsed seconds
   int m_mode, m_secs, m_lap;
   bit m_lv, m_ovf;

   function automatic logic [15:0] to_bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_secs = 0; m_lap = 0; m_lv = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit c, input bit s, input bit l, input bit t);
      int  nmode = m_mode, nsecs = m_secs, nlap = m_lap;
      bit  nlv = m_lv, novf = m_ovf;
      if (m_mode == 1 && t) begin
         if (m_secs == MAX_SECS) begin
            novf = 1; nmode = 2;
         end else begin
            nsecs = m_secs + 1;
         end
      end
      if (c) begin
         if (m_mode != 1) begin
            nmode = 0; nsecs = 0; nlap = 0; nlv = 0; novf = 0;
         end
      end else if (s) begin
         if (m_mode == 0) nmode = 1;
         else if (m_mode == 1) nmode = 2;
         else if (!m_ovf) nmode = 1;
      end else if (l && LAP_EN) begin
         if (m_mode == 1) begin
            nlap = m_secs; nlv = 1;
         end else if (m_mode == 2 && m_lv) begin
            nlv = 0;
         end
      end
      m_mode = nmode; m_secs = nsecs; m_lap = nlap; m_lv = nlv; m_ovf = novf;
   endtask

   function automatic logic [15:0] disp();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] d, input bit r,
                          input bit lv, input bit ov);
      chk({tag, ".digits"}, disp(), d);
      chk({tag, ".running"}, 16'(running), 16'(r));
      chk({tag, ".lap_view"}, 16'(lap_view), 16'(lv));
      chk({tag, ".overflow"}, 16'(overflow), 16'(ov));
   endtask

   // Apply one cycle of pulses, then sample 1 time unit after the edge
   task automatic step(input bit c, input bit s, input bit l, input bit t);
      clear = c; start_stop = s; lap = l; clk_div = t;
      @(posedge clk);
      #1;
      model_step(c, s, l, t);
      clear = 0; start_stop = 0; lap = 0; clk_div = 0;
   endtask

   typedef struct {
      bit          c, s, l, t;
      int          reps;
      logic [15:0] d_lap;   // display when lap feature present
      logic [15:0] d_live;  // live count (display without lap feature)
      bit          run, lv, ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit c, bit s, bit l, bit t, int reps,
                               logic [15:0] dl, logic [15:0] dv,
                               bit r, bit lv, bit ov);
      vec_t v;
      v.c = c; v.s = s; v.l = l; v.t = t; v.reps = reps;
      v.d_lap = dl; v.d_live = dv; v.run = r; v.lv = lv; v.ovf = ov;
      return v;
   endfunction

   initial begin
      //                  c  s  l  t  reps  disp(lap)  live      run lv ovf
      vecs.push_back(mk(0, 1, 0, 1, 1,   16'h0000, 16'h0000, 1, 0, 0)); // tick at start not counted
      vecs.push_back(mk(0, 0, 0, 1, 75,  16'h0115, 16'h0115, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1,   16'h0115, 16'h0115, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 5,   16'h0115, 16'h0115, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1,   16'h0115, 16'h0115, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 3,   16'h0118, 16'h0118, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1,   16'h0118, 16'h0119, 1, 1, 0)); // lap captures pre-tick
      vecs.push_back(mk(0, 0, 0, 1, 10,  16'h0118, 16'h0129, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1,   16'h0118, 16'h0129, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1,   16'h0129, 16'h0129, 0, 0, 0)); // release to live
      vecs.push_back(mk(0, 1, 0, 0, 1,   16'h0129, 16'h0129, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1,   16'h0129, 16'h0129, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1,   16'h0129, 16'h0130, 1, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 1,   16'h0129, 16'h0130, 1, 1, 0)); // clear ignored, lap dropped
      vecs.push_back(mk(0, 1, 1, 0, 1,   16'h0129, 16'h0130, 0, 1, 0)); // lap dropped under start_stop
      vecs.push_back(mk(1, 1, 0, 0, 1,   16'h0000, 16'h0000, 0, 0, 0)); // clear wins in PAUSE
      vecs.push_back(mk(0, 0, 1, 0, 1,   16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1,   16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1,   16'h0000, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 59,  16'h0059, 16'h0059, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1,   16'h0100, 16'h0100, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 179, 16'h0359, 16'h0359, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1,   16'h0359, 16'h0359, 0, 0, 1)); // saturating tick
      vecs.push_back(mk(0, 1, 0, 0, 1,   16'h0359, 16'h0359, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1,   16'h0359, 16'h0359, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 1,   16'h0000, 16'h0000, 0, 0, 0));

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 16'h0000, 0, 0, 0);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++)
            step(vecs[i].c, vecs[i].s, vecs[i].l, vecs[i].t);
         chk_all($sformatf("vec%0d", i), LAP_EN ? vecs[i].d_lap : vecs[i].d_live,
                 vecs[i].run, LAP_EN ? vecs[i].lv : 1'b0, vecs[i].ovf);
      end

      // Asynchronous reset in the middle of a run
      step(0, 1, 0, 0);
      for (int r = 0; r < 207; r++) step(0, 0, 0, 1);
      chk_all("pre_reset", 16'h0327, 1, 0, 0);
      #2;
      nrst = 1'b0;
      #1;
      chk_all("async_reset", 16'h0000, 0, 0, 0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      model_reset();
      step(0, 0, 0, 1);
      chk_all("post_reset_tick", 16'h0000, 0, 0, 0);

      // Randomized run against the reference model
      for (int n = 0; n < 6000; n++) begin
         bit rc, rs, rl, rt;
         rc = ($urandom_range(0, 79) == 0);
         rs = ($urandom_range(0, 14) == 0);
         rl = ($urandom_range(0, 11) == 0);
         rt = ($urandom_range(0, 1) == 0);
         step(rc, rs, rl, rt);
         chk_all("rand", m_lv ? to_bcd(m_lap) : to_bcd(m_secs),
                 (m_mode == 1), m_lv, m_ovf);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
